// File: rtl/draw_fill_pkg.sv
// draw_fill_pkg: shared geometry, register map, bit positions and FSM states
// for the draw-buffer fill engine.
package draw_fill_pkg;
    localparam int ROW_WORDS = 40;
    localparam int ROWS      = 240;
    localparam int DEPTH     = ROW_WORDS * ROWS;
    localparam int AW        = 14;

    localparam logic [2:0] REG_X0     = 3'd0;
    localparam logic [2:0] REG_Y0     = 3'd1;
    localparam logic [2:0] REG_W      = 3'd2;
    localparam logic [2:0] REG_H      = 3'd3;
    localparam logic [2:0] REG_COLOR  = 3'd4;
    localparam logic [2:0] REG_CTRL   = 3'd5;
    localparam logic [2:0] REG_STATUS = 3'd6;
    localparam logic [2:0] REG_COUNT  = 3'd7;

    localparam int CTRL_START  = 0;
    localparam int CTRL_ABORT  = 1;
    localparam int CTRL_IRQ_EN = 2;

    localparam int ST_BUSY    = 0;
    localparam int ST_DONE    = 1;
    localparam int ST_ERROR   = 2;
    localparam int ST_ABORTED = 3;

    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_FILL, S_DONE} state_t;
endpackage

// File: rtl/draw_fill_ctrl_if.sv
// draw_fill_ctrl_if: CSR slave bus plus the draw-buffer write port (second RAM
// port, no waitrequest). The slave modport is the fill engine's view.
interface draw_fill_ctrl_if;
    import draw_fill_pkg::*;
    logic [2:0]    csr_address;
    logic          csr_chipselect;
    logic          csr_write;
    logic          csr_read;
    logic [31:0]   csr_writedata;
    logic [31:0]   csr_readdata;
    logic          irq;
    logic [AW-1:0] mem_address;
    logic          mem_chipselect;
    logic          mem_write;
    logic [3:0]    mem_byteenable;
    logic [31:0]   mem_writedata;
    logic          mem_clken;

    modport slave (
        input  csr_address, csr_chipselect, csr_write, csr_read, csr_writedata,
        output csr_readdata, irq,
        output mem_address, mem_chipselect, mem_write, mem_byteenable, mem_writedata, mem_clken
    );
    modport master (
        output csr_address, csr_chipselect, csr_write, csr_read, csr_writedata,
        input  csr_readdata, irq,
        input  mem_address, mem_chipselect, mem_write, mem_byteenable, mem_writedata, mem_clken
    );
endinterface

// File: rtl/draw_fill_addr_gen.sv
// draw_fill_addr_gen: walks a W x H word rectangle row by row, producing the
// buffer address of the current word and flagging the final word.
module draw_fill_addr_gen
    import draw_fill_pkg::*;
#(
    parameter int ROW_WORDS = 40
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_load,
    input  logic          i_step,
    input  logic [AW-1:0] i_base,
    input  logic [6:0]    i_w,
    input  logic [8:0]    i_h,
    output logic [AW-1:0] o_addr,
    output logic          o_last
);
    logic [AW-1:0] r_addr, r_row_start;
    logic [6:0]    r_col, r_w;
    logic [8:0]    r_row, r_h;
    logic          w_eol;

    assign w_eol  = r_col == r_w - 7'd1;
    assign o_last = w_eol && r_row == r_h - 9'd1;
    assign o_addr = r_addr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr      <= '0;
            r_row_start <= '0;
            r_col       <= '0;
            r_row       <= '0;
            r_w         <= '0;
            r_h         <= '0;
        end else if (i_load) begin
            r_addr      <= i_base;
            r_row_start <= i_base;
            r_col       <= '0;
            r_row       <= '0;
            r_w         <= i_w;
            r_h         <= i_h;
        end else if (i_step) begin
            if (w_eol) begin
                r_col       <= '0;
                r_row       <= r_row + 9'd1;
                r_row_start <= r_row_start + AW'(ROW_WORDS);
                r_addr      <= r_row_start + AW'(ROW_WORDS);
            end else begin
                r_col  <= r_col + 7'd1;
                r_addr <= r_addr + AW'(1);
            end
        end
    end
endmodule

// File: rtl/draw_fill_ctrl.sv
// draw_fill_ctrl: CSR-programmed rectangle fill engine; writes one colour word
// per cycle into the draw buffer, with bounds check, abort and irq.
module draw_fill_ctrl
    import draw_fill_pkg::*;
#(
    parameter int ROW_WORDS = 40,
    parameter int ROWS      = 240
) (
    input logic             clk,
    input logic             reset,
    draw_fill_ctrl_if.slave bus
);
    state_t      r_state;
    logic [5:0]  r_x0, r_wx0;
    logic [7:0]  r_y0, r_wy0;
    logic [6:0]  r_w, r_ww;
    logic [8:0]  r_h, r_wh;
    logic [31:0] r_color, r_wcolor, r_rdata, w_rmux, w_status;
    logic [13:0] r_count, w_row_base, w_addr;
    logic        r_irq_en, r_done, r_error, r_aborted;
    logic        w_wr, w_ctrl_wr, w_start, w_abort, w_busy, w_fill, w_bad, w_last;

    assign w_wr      = bus.csr_chipselect & bus.csr_write;
    assign w_ctrl_wr = w_wr && bus.csr_address == REG_CTRL;
    assign w_abort   = w_ctrl_wr & bus.csr_writedata[CTRL_ABORT];
    assign w_start   = w_ctrl_wr & bus.csr_writedata[CTRL_START] & ~bus.csr_writedata[CTRL_ABORT];
    assign w_busy    = r_state != S_IDLE;
    assign w_fill    = r_state == S_FILL;
    assign w_bad     = r_ww == '0 || r_wh == '0 ||
                       10'(r_wx0) + 10'(r_ww) > 10'(ROW_WORDS) ||
                       10'(r_wy0) + 10'(r_wh) > 10'(ROWS);
    // Y0*40 as (Y0*32 + Y0*8) keeps the row base multiplier-free.
    assign w_row_base = (14'(r_wy0) << 5) + (14'(r_wy0) << 3);

    draw_fill_addr_gen #(.ROW_WORDS(ROW_WORDS)) u_addr_gen (
        .clk    (clk),
        .reset  (reset),
        .i_load (r_state == S_CHECK && !w_bad),
        .i_step (w_fill && !w_last),
        .i_base (w_row_base + 14'(r_wx0)),
        .i_w    (r_ww),
        .i_h    (r_wh),
        .o_addr (w_addr),
        .o_last (w_last)
    );

    // Reset gates the strobes combinationally so a write in the reset cycle is dropped.
    assign bus.mem_chipselect = w_fill & ~reset;
    assign bus.mem_write      = w_fill & ~reset;
    assign bus.mem_byteenable = (w_fill & ~reset) ? 4'hF : 4'h0;
    assign bus.mem_writedata  = (w_fill & ~reset) ? r_wcolor : 32'd0;
    assign bus.mem_address    = w_addr;
    assign bus.mem_clken      = 1'b1;
    assign bus.irq            = r_irq_en & (r_done | r_error);
    assign bus.csr_readdata   = r_rdata;

    always_comb begin
        w_status             = '0;
        w_status[ST_BUSY]    = w_busy;
        w_status[ST_DONE]    = r_done;
        w_status[ST_ERROR]   = r_error;
        w_status[ST_ABORTED] = r_aborted;
        w_rmux               = '0;
        case (bus.csr_address)
            REG_X0:     w_rmux = 32'(r_x0);
            REG_Y0:     w_rmux = 32'(r_y0);
            REG_W:      w_rmux = 32'(r_w);
            REG_H:      w_rmux = 32'(r_h);
            REG_COLOR:  w_rmux = r_color;
            REG_CTRL:   w_rmux = 32'(r_irq_en) << CTRL_IRQ_EN;
            REG_STATUS: w_rmux = w_status;
            default:    w_rmux = 32'(r_count);
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            {r_x0, r_wx0, r_y0, r_wy0, r_w, r_ww, r_h, r_wh} <= '0;
            r_color   <= '0;
            r_wcolor  <= '0;
            r_rdata   <= '0;
            r_count   <= '0;
            r_irq_en  <= 1'b0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
            r_aborted <= 1'b0;
        end else begin
            r_rdata <= (bus.csr_chipselect & bus.csr_read) ? w_rmux : 32'd0;
            if (w_wr && !w_busy && bus.csr_address == REG_X0)    r_x0    <= bus.csr_writedata[5:0];
            if (w_wr && !w_busy && bus.csr_address == REG_Y0)    r_y0    <= bus.csr_writedata[7:0];
            if (w_wr && !w_busy && bus.csr_address == REG_W)     r_w     <= bus.csr_writedata[6:0];
            if (w_wr && !w_busy && bus.csr_address == REG_H)     r_h     <= bus.csr_writedata[8:0];
            if (w_wr && !w_busy && bus.csr_address == REG_COLOR) r_color <= bus.csr_writedata;
            if (w_ctrl_wr) r_irq_en <= bus.csr_writedata[CTRL_IRQ_EN];
            if (w_wr && bus.csr_address == REG_STATUS) begin
                if (bus.csr_writedata[ST_DONE])    r_done    <= 1'b0;
                if (bus.csr_writedata[ST_ERROR])   r_error   <= 1'b0;
                if (bus.csr_writedata[ST_ABORTED]) r_aborted <= 1'b0;
            end
            if (w_fill) r_count <= r_count + 14'd1;
            if (w_abort && w_busy) begin
                r_state   <= S_IDLE;
                r_aborted <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: if (w_start) begin
                        {r_wx0, r_wy0, r_ww, r_wh, r_wcolor} <= {r_x0, r_y0, r_w, r_h, r_color};
                        r_count   <= '0;
                        r_done    <= 1'b0;
                        r_error   <= 1'b0;
                        r_aborted <= 1'b0;
                        r_state   <= S_CHECK;
                    end
                    S_CHECK: begin
                        r_error <= w_bad;
                        r_state <= w_bad ? S_IDLE : S_FILL;
                    end
                    S_FILL: r_state <= w_last ? S_DONE : S_FILL;
                    default: begin
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: doc/draw_fill_ctrl.md
DRAW_FILL_CTRL -- requirements
Module: draw_fill_ctrl

Interface
REQ-001 SHALL have parameter ROW_WORDS, default 40, words per display row.
REQ-002 SHALL have parameter ROWS, default 240, display rows; ROW_WORDS*ROWS = 9600 = buffer depth.
REQ-003 SHALL have one clock and a synchronous, active-high reset: clk  in  1  sole clock; reset  in  1  synchronous active-high reset.
REQ-004 SHALL have CSR slave port: csr_address in 3, csr_chipselect in 1, csr_write in 1, csr_read in 1, csr_writedata in 32, csr_readdata out 32 (read latency 1), irq out 1.
REQ-005 SHALL have buffer master port: mem_address out 14, mem_chipselect out 1, mem_write out 1, mem_byteenable out 4, mem_writedata out 32, mem_clken out 1 (tied 1); it drives the second port of the draw buffer RAM, which has no waitrequest.

Function
REQ-006 SHALL decode registers: 0 X0[5:0] word column, 1 Y0[7:0] row, 2 W[6:0] width in words, 3 H[8:0] height in rows, 4 COLOR[31:0], 5 CTRL (write: bit0 start, bit1 abort; r/w: bit2 irq_en), 6 STATUS (bit0 busy, bit1 done, bit2 error, bit3 aborted; write-1-to-clear bits1-3), 7 COUNT[13:0] words written by last operation (read-only).
REQ-007 SHALL ignore writes to registers 0-4 and start while busy; abort is accepted only while busy.
REQ-008 SHALL implement FSM IDLE -> CHECK -> FILL -> DONE -> IDLE; busy=1 in CHECK, FILL and DONE.
REQ-009 IDLE: a start write latches X0,Y0,W,H,COLOR into working copies, clears COUNT and done/error/aborted, and enters CHECK next cycle.
REQ-010 CHECK (1 cycle): if W=0, H=0, X0+W>ROW_WORDS or Y0+H>ROWS, SHALL set error and return to IDLE with no memory write; otherwise compute row_base = Y0*40 by shift-add ((Y0<<5)+(Y0<<3)), no multiplier, and enter FILL.
REQ-011 FILL: one write per cycle, mem_chipselect=mem_write=1, mem_byteenable=4'hF, mem_writedata=COLOR, mem_address=row_base+X0+col; col runs 0..W-1, then col=0, row_base+=ROW_WORDS, row+=1.
REQ-012 First write SHALL occur 2 cycles after the start write cycle; the operation issues exactly W*H consecutive writes with no gaps; COUNT increments on each.
REQ-013 After the write at (col=W-1,row=H-1) SHALL enter DONE; DONE sets done and returns to IDLE next cycle.
REQ-014 irq SHALL equal irq_en & (done | error), level-sensitive, cleared by W1C on STATUS.
REQ-015 Abort while busy: no further writes from the next cycle; FSM to IDLE; aborted=1; done stays 0; COUNT holds words already written.
REQ-016 Start and abort in the same CTRL write: abort takes precedence; while idle the write has no effect.
REQ-017 mem_chipselect and mem_write SHALL be 0 in every state except FILL.
REQ-018 mem_address SHALL never exceed 9599.

Reset
REQ-019 On reset SHALL: FSM=IDLE; all registers, COUNT, STATUS, irq_en = 0; csr_readdata=0; irq=0; mem_chipselect=mem_write=0; mem_address=0; mem_byteenable=0; mem_writedata=0.
REQ-020 Reset mid-FILL SHALL suppress writes in the same cycle it is sampled; no operation resumes afterwards.

Structure
REQ-021 Package draw_fill_pkg SHALL hold ROW_WORDS, ROWS, DEPTH=9600, register offsets, STATUS/CTRL bit positions and the FSM state enum.
REQ-022 Address/column/row stepping SHALL be a sub-module draw_fill_addr_gen (load, step, last outputs); CSR decode and FSM remain in draw_fill_ctrl.

Verification
REQ-023 Full clear: X0=0,Y0=0,W=40,H=240,COLOR=0 -> 9600 writes, addresses 0..9599 consecutive, done=1, COUNT=9600, busy for 9603 cycles.
REQ-024 Corner: X0=38,Y0=239,W=2,H=1,COLOR=0xA5A5A5A5 -> exactly two writes at addresses 9598,9599, data 0xA5A5A5A5, byteenable 4'hF.
REQ-025 Rectangle: X0=1,Y0=2,W=3,H=2 -> writes at 81,82,83,121,122,123 in order, then done; irq=1 with irq_en=1, irq=0 after writing 0x2 to STATUS.
REQ-026 Error: X0=39,W=2,H=1 -> no writes, error=1, busy drops after 2 cycles; W=0 -> same.
REQ-027 Abort after 5 writes of a W=10,H=1 fill -> no 6th write, aborted=1, done=0, COUNT=5; start+abort together when idle -> no writes.
REQ-028 Reset asserted mid-FILL, and second start/param writes while busy -> no writes after reset, STATUS=0; parameters of the running fill unchanged.
